// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO phase feeder and its cordic instance.
package nco_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PH_BITS_DEF = 32;
  localparam int XY_BITS_DEF = 12;

  // 1/1.6468 in Q0.16; pre-scaling by it keeps the rotated vector inside full scale
  localparam int CORDIC_GAIN_INV_Q16 = 39797;
  localparam int AMP_DEF             = (2047 * CORDIC_GAIN_INV_Q16) >>> 16;

endpackage

// File: rtl/nco_rate_div.sv
// Sample-rate down-counter: ticks at zero and reloads with the divider minus one.
module nco_rate_div #(
  parameter int DIV_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] load,
  output logic                tick
);

  logic [DIV_BITS-1:0] cnt_reg;

  assign tick = (cnt_reg == '0);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= tick ? load : cnt_reg - DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/nco_phase_gen.sv
// Paced phase-sample generator feeding a ROTATE-mode cordic to form a cos/sin NCO.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int XY_BITS  = XY_BITS_DEF,
  parameter int PH_BITS  = PH_BITS_DEF,
  parameter int DIV_BITS = 16,
  parameter int CNT_BITS = 16,
  parameter int AMP      = AMP_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PH_BITS-1:0]        cfg_freq,
  input  logic [PH_BITS-1:0]        cfg_phase,
  input  logic [DIV_BITS-1:0]       cfg_div,
  input  logic [CNT_BITS-1:0]       cfg_count,
  input  logic                      stop,
  output logic                      ivalid,
  output logic signed [XY_BITS-1:0] x_i,
  output logic signed [XY_BITS-1:0] y_i,
  output logic [PH_BITS-1:0]        z_i,
  output logic                      busy,
  output logic                      done
);

  state_t               state_reg, state_next;
  logic [PH_BITS-1:0]   acc_reg, acc_next;
  logic [PH_BITS-1:0]   freq_reg, freq_next;
  logic [PH_BITS-1:0]   phase_reg, phase_next;
  logic [DIV_BITS-1:0]  div_reg, div_next;
  logic [CNT_BITS-1:0]  rem_reg, rem_next;
  logic                 cont_reg, cont_next;
  logic                 ivalid_next, done_next;
  logic [XY_BITS-1:0]   x_next, y_next;
  logic [PH_BITS-1:0]   z_next;
  logic                 tick;
  logic                 in_run;

  assign in_run    = (state_reg == RUN);
  assign busy      = in_run;
  assign cfg_ready = !reset && (state_reg == IDLE);

  // Held cleared while idle, so the first tick lands on the edge after acceptance
  nco_rate_div #(
    .DIV_BITS(DIV_BITS)
  ) u_rate_div (
    .clock (clock),
    .reset (reset),
    .clear (!in_run),
    .enable(in_run),
    .load  (div_reg - DIV_BITS'(1)),
    .tick  (tick)
  );

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    freq_next   = freq_reg;
    phase_next  = phase_reg;
    div_next    = div_reg;
    rem_next    = rem_reg;
    cont_next   = cont_reg;
    ivalid_next = 1'b0;
    done_next   = 1'b0;
    x_next      = x_i;
    y_next      = y_i;
    z_next      = z_i;
    case (state_reg)
      IDLE: begin
        if (cfg_valid) begin
          freq_next  = cfg_freq;
          phase_next = cfg_phase;
          div_next   = (cfg_div == '0) ? DIV_BITS'(1) : cfg_div;
          rem_next   = cfg_count;
          cont_next  = (cfg_count == '0);
          acc_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // An abort takes priority over any sample due on the same edge
        if (stop) begin
          state_next = IDLE;
        end else if (tick) begin
          ivalid_next = 1'b1;
          z_next      = acc_reg + phase_reg;
          x_next      = XY_BITS'(AMP);
          y_next      = '0;
          acc_next    = acc_reg + freq_reg;
          if (!cont_reg) begin
            rem_next = rem_reg - CNT_BITS'(1);
            if (rem_reg == CNT_BITS'(1)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      freq_reg  <= '0;
      phase_reg <= '0;
      div_reg   <= DIV_BITS'(1);
      rem_reg   <= '0;
      cont_reg  <= 1'b0;
      ivalid    <= 1'b0;
      done      <= 1'b0;
      x_i       <= '0;
      y_i       <= '0;
      z_i       <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      freq_reg  <= freq_next;
      phase_reg <= phase_next;
      div_reg   <= div_next;
      rem_reg   <= rem_next;
      cont_reg  <= cont_next;
      ivalid    <= ivalid_next;
      done      <= done_next;
      x_i       <= x_next;
      y_i       <= y_next;
      z_i       <= z_next;
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Randomized self-checking bench for nco_phase_gen against a closed-form sample schedule.
module tb_nco_phase_gen;

  logic               clock;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_freq;
  logic [31:0]        cfg_phase;
  logic [15:0]        cfg_div;
  logic [15:0]        cfg_count;
  logic               stop;
  logic               ivalid;
  logic signed [11:0] x_i;
  logic signed [11:0] y_i;
  logic [31:0]        z_i;
  logic               busy;
  logic               done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_z    = '0;

  nco_phase_gen dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_freq (cfg_freq),
    .cfg_phase(cfg_phase),
    .cfg_div  (cfg_div),
    .cfg_count(cfg_count),
    .stop     (stop),
    .ivalid   (ivalid),
    .x_i      (x_i),
    .y_i      (y_i),
    .z_i      (z_i),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: after acceptance at edge N, sample k appears after edge N+1+k*d with
  // z = phase + k*freq (mod 2^32). A stop before edge of sample nstop+1 aborts.
  task automatic run_cfg(input logic [31:0] f, input logic [31:0] ph, input logic [15:0] dv,
                         input logic [15:0] cnt, input int nstop, input bit poke);
    int          d, nsamp, last, endc;
    bit          stopping, iv, dn;
    logic [31:0] k;
    d        = (dv == 16'd0) ? 1 : int'(dv);
    stopping = (cnt == 16'd0) || (nstop < int'(cnt));
    nsamp    = stopping ? nstop : int'(cnt);
    last     = 1 + (nsamp - 1) * d;
    endc     = stopping ? last + d : last;
    k        = '0;
    cfg_freq  = f;
    cfg_phase = ph;
    cfg_div   = dv;
    cfg_count = cnt;
    cfg_valid = 1'b1;
    check("ready_idle", cfg_ready, 1);
    @(posedge clock); #1;
    cfg_valid = 1'b0;
    check("busy_accept", busy, 1);
    check("ready_run", cfg_ready, 0);
    check("ivalid_accept", ivalid, 0);
    for (int c = 1; c <= endc + 1; c++) begin
      stop = stopping && (c == endc);
      if (poke && c == 2 && c < endc) begin
        cfg_valid = 1'b1;
        cfg_freq  = $urandom;
        cfg_phase = $urandom;
        cfg_div   = 16'($urandom_range(0, 3));
        cfg_count = 16'($urandom_range(0, 3));
        check("ready_poke", cfg_ready, 0);
      end else begin
        cfg_valid = 1'b0;
      end
      @(posedge clock); #1;
      iv = (c <= last) && ((c - 1) % d == 0);
      dn = iv && !stopping && (c == last);
      if (iv) begin
        exp_z = ph + f * k;
        k     = k + 32'd1;
        check("x_i", x_i, 1243);
        check("y_i", y_i, 0);
      end
      check("ivalid", ivalid, iv);
      check("done", done, dn);
      check("busy", busy, c < endc);
      check("z_i", z_i, exp_z);
    end
    stop      = 1'b0;
    cfg_valid = 1'b0;
    check("ready_after", cfg_ready, 1);
    $display("run freq=%h phase=%h div=%0d count=%0d samples=%0d stopped=%0d",
             f, ph, dv, cnt, nsamp, stopping);
  endtask

  initial begin
    logic [15:0] rc, rd;
    int          ns;
    reset = 1'b1; cfg_valid = 1'b0; stop = 1'b0;
    cfg_freq = '0; cfg_phase = '0; cfg_div = '0; cfg_count = '0;
    repeat (3) @(posedge clock);
    #1;
    check("ready_in_reset", cfg_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_ivalid", ivalid, 0);
    check("rst_busy", busy, 0);
    check("rst_z", z_i, 0);
    check("rst_done", done, 0);
    check("rst_ready", cfg_ready, 1);

    run_cfg(32'h4000_0000, 32'h0, 16'd1, 16'd4, 4, 1'b0);
    run_cfg(32'h10, 32'h5, 16'd3, 16'd3, 3, 1'b1);
    run_cfg(32'h10, 32'h5, 16'd0, 16'd3, 3, 1'b0);
    run_cfg(32'hC000_0000, 32'h8000_0000, 16'd1, 16'd3, 3, 1'b0);
    run_cfg(32'h0123_4567, 32'h89AB_CDEF, 16'd2, 16'd0, 5, 1'b1);
    run_cfg(32'h100, 32'h7, 16'd2, 16'd3, 2, 1'b0);

    for (int i = 0; i < 25; i++) begin
      rd = 16'($urandom_range(0, 4));
      rc = 16'($urandom_range(0, 6));
      if (rc == 16'd0)              ns = $urandom_range(1, 5);
      else if ($urandom_range(0, 3) == 0 && rc > 16'd1) ns = $urandom_range(1, int'(rc) - 1);
      else                          ns = int'(rc);
      run_cfg($urandom, $urandom, rd, rc, ns, 1'($urandom_range(0, 1)));
    end

    cfg_freq = 32'h1111_1111; cfg_phase = 32'h2; cfg_div = 16'd1; cfg_count = 16'd0;
    cfg_valid = 1'b1;
    @(posedge clock); #1;
    cfg_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("pre_rst_ivalid", ivalid, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_ivalid", ivalid, 0);
    check("midrst_z", z_i, 0);
    check("midrst_x", x_i, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cfg_ready, 0);
    reset = 1'b0;
    exp_z = '0;
    @(posedge clock); #1;
    run_cfg(32'h0000_0100, 32'h0000_0ABC, 16'd1, 16'd2, 2, 1'b0);
    $display("reset mid-run then restart done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nco_phase_gen.md
Name: nco_phase_gen

Overview:
- Upstream feeder for the ROTATE-mode cordic (XY_BITS 12, PH_BITS 32).
- Generates a paced stream of phase samples from a programmable frequency word, phase offset, rate divider and burst length.
- Drives the cordic's ivalid/x_i/y_i/z_i inputs, so the cordic outputs x_o/y_o form a cos/sin NCO.
- Configured through a valid/ready handshake; runs continuously or for a fixed burst.

Parameters:
XY_BITS, 12, width of x_i/y_i (signed), matches cordic XY_BITS
PH_BITS, 32, width of phase accumulator and z_i; full scale 2^PH_BITS = one turn
DIV_BITS, 16, width of rate divider value
CNT_BITS, 16, width of burst count
AMP, 1243, x_i amplitude, pre-scaled by 1/cordic gain (2047/1.6468)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_freq  in  PH_BITS  phase increment per sample (unsigned)
cfg_phase  in  PH_BITS  phase offset added to every sample
cfg_div  in  DIV_BITS  clocks per sample; 0 treated as 1
cfg_count  in  CNT_BITS  samples in burst; 0 = continuous
stop  in  1  abort run
ivalid  out  1  sample strobe to cordic
x_i  out  XY_BITS  AMP on every sample
y_i  out  XY_BITS  always 0
z_i  out  PH_BITS  phase sample = acc + offset
busy  out  1  high in RUN
done  out  1  one-cycle pulse on natural burst completion

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clock, reset port is reset.
- All outputs are registered. Reset values: state IDLE, ivalid 0, done 0, busy 0, x_i 0, y_i 0, z_i 0, accumulator 0. cfg_ready is 0 during reset and combinational thereafter (equal to state==IDLE).
- States: IDLE and RUN.
- IDLE: cfg_ready=1, stop is ignored.
  - On cfg_valid at an edge, latch freq, phase, div (0→1) and count; clear acc, rem←count and div_cnt←0; go to RUN.
- RUN: busy=1, cfg_ready=0; cfg_valid is ignored.
  - Each edge where div_cnt==0 and stop==0:
    - ivalid←1, z_i←acc+phase (mod 2^PH_BITS), x_i←AMP, y_i←0;
    - acc←acc+freq (mod 2^PH_BITS, wraps silently);
    - div_cnt←div-1.
  - Otherwise div_cnt←div_cnt-1 and ivalid←0.
- Latency: with acceptance at edge N, the first ivalid is high in the cycle after edge N+1. Samples are then spaced exactly div cycles apart. With div=1, ivalid is high every cycle.
- Burst (count≠0): each emission decrements rem.
  - The emission with rem==1 sets state←IDLE and done←1 on the same edge, so done coincides with the last ivalid.
  - Exactly count samples are emitted.
- Continuous (count=0): runs until stop; rem is not used.
- stop in RUN: state←IDLE on the next edge, with no emission that edge even if div_cnt==0. done stays 0 and acc is left as is.
- stop and the final-sample edge coincide: stop wins; no sample is emitted and done stays 0.
- x_i/y_i/z_i hold their last values between strobes.
- There is no backpressure; the cordic accepts ivalid every cycle.
- Reset mid-run returns to IDLE at the next edge with outputs at their reset values.

Decomposition:
- Shared package nco_pkg holds:
  - state enum {IDLE, RUN};
  - CORDIC_GAIN_INV constant and default AMP;
  - PH_BITS and XY_BITS defaults shared with the cordic instantiation.
- One sub-module, nco_rate_div: a down-counter with load value, clear and tick output (tick when count==0, reload div-1).
- The accumulator and FSM stay in nco_phase_gen.

Test Plan:
1. Reset held 3 cycles, then released → ivalid=0, busy=0, z_i=0, cfg_ready=1.
2. Basic burst: freq=0x4000_0000, phase=0, div=1, count=4 → ivalid for 4 consecutive cycles with z_i = 0x0, 0x4000_0000, 0x8000_0000, 0xC000_0000; x_i=1243, y_i=0; done pulse with the 4th sample; then IDLE and cfg_ready=1.
3. Divider and offset: div=3, freq=0x10, phase=0x5, count=3 → ivalid every 3rd cycle with z_i = 0x5, 0x15, 0x25; div=0 behaves exactly like div=1.
4. Phase wrap: freq=0xC000_0000, phase=0x8000_0000, count=3 → z_i = 0x8000_0000, 0x4000_0000, 0x0000_0000 (mod 2^32).
5. Continuous run then stop:
   - count=0, div=2; assert stop on a tick cycle after 5 samples → no 6th sample, done=0, busy=0 next cycle.
   - cfg_valid during RUN is not accepted (cfg_ready=0).
6. Reset during RUN (count=0, div=1) → next edge ivalid=0, z_i=0, IDLE; a following config restarts with acc=0 and first z_i=phase.
